// File: rtl/sram_mem_ctrl_if.sv
// MEM-stage request bus between the pipeline and the SRAM controller.
//   rd_en / wr_en : level requests, held while ready is low
//   address       : byte address (ALU result)
//   wr_data       : store data
//   rd_data       : load data, valid while ready is high at the end of a read
//   ready         : access complete or no access pending (pipeline freeze is ~ready)
interface sram_mem_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, wr_data,
    input  rd_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, wr_data,
    output rd_data, ready
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Sequences MEM-stage word accesses onto a 16-bit SRAM as two half-word transfers,
// low half first, each lasting WaitCycles+1 cycles. ready stays low for the whole access.
// Ports:
//   clk_i, rst_ni    clock (rising edge), asynchronous active-low reset
//   mem_bus          MEM-stage request bus (slave side)
//   sram_addr_o      SRAM half-word address
//   sram_dq_out_o    SRAM write data, sram_dq_oe_o enables it onto the bus
//   sram_dq_in_i     SRAM read data
//   sram_we_n_o      SRAM write strobe, active-low
//   stall_count_o    cycles with ready low (only with SRAM_MEM_CTRL_PERF_EN defined)
// Optional feature macro: SRAM_MEM_CTRL_PERF_EN
module sram_mem_ctrl #(
  parameter int unsigned WaitCycles = 1,
  parameter int unsigned SramAw     = 18,
  parameter int unsigned MemBase    = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  sram_mem_ctrl_if.slave      mem_bus,
  output logic [SramAw-1:0]   sram_addr_o,
  output logic [15:0]         sram_dq_out_o,
  output logic                sram_dq_oe_o,
  input  logic [15:0]         sram_dq_in_i,
  output logic                sram_we_n_o
`ifdef SRAM_MEM_CTRL_PERF_EN
  ,
  output logic [31:0]         stall_count_o
`endif
);

  localparam int unsigned CntW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WaitCycles);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_wr_q;
  logic [15:0]       wdata_hi_q;
  logic [31:0]       rd_data_q;
  logic [SramAw-1:0] sram_addr_q;
  logic [15:0]       dq_out_q;

  logic        req;
  logic        phase_last;
  logic        active;
  logic [31:0] offset;

  assign req        = mem_bus.rd_en | mem_bus.wr_en;
  assign phase_last = (cnt_q == CntLast);
  assign offset     = mem_bus.address - 32'(MemBase);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLo;
          cnt_d   = '0;
        end
      end
      StLo: begin
        if (phase_last) begin
          state_d = StHi;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHi: begin
        if (phase_last) state_d = StDone;
        else            cnt_d   = cnt_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; strobes derive from state so a reset releases them immediately
  always_comb begin
    active        = (state_q == StLo) || (state_q == StHi);
    sram_we_n_o   = ~(active & op_wr_q);
    sram_dq_oe_o  = active & op_wr_q;
    mem_bus.ready = (state_q == StDone) || ((state_q == StIdle) && !req);
  end

  // Datapath: captured request, SRAM address/data, read assembly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_wr_q     <= 1'b0;
      wdata_hi_q  <= '0;
      rd_data_q   <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
    end else begin
      if (state_q == StIdle && req) begin
        // Write wins when both requests are high
        op_wr_q     <= mem_bus.wr_en;
        sram_addr_q <= {offset[SramAw:2], 1'b0};
        if (mem_bus.wr_en) begin
          dq_out_q   <= mem_bus.wr_data[15:0];
          wdata_hi_q <= mem_bus.wr_data[31:16];
        end
      end
      if (state_q == StLo && phase_last) begin
        sram_addr_q <= {sram_addr_q[SramAw-1:1], 1'b1};
        if (op_wr_q) dq_out_q <= wdata_hi_q;
        else         rd_data_q[15:0] <= sram_dq_in_i;
      end
      if (state_q == StHi && phase_last && !op_wr_q) begin
        rd_data_q[31:16] <= sram_dq_in_i;
      end
    end
  end

  assign sram_addr_o     = sram_addr_q;
  assign sram_dq_out_o   = dq_out_q;
  assign mem_bus.rd_data = rd_data_q;

`ifdef SRAM_MEM_CTRL_PERF_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             stall_count_q <= '0;
    else if (!mem_bus.ready) stall_count_q <= stall_count_q + 32'd1;
  end

  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT0: one wait state, registered SRAM model (data one cycle after address)
  sram_mem_ctrl_if bus0 ();
  logic [17:0] addr0;
  logic [15:0] dq_out0, dq_in0;
  logic        oe0, we_n0;
  bit   [15:0] mem0 [0:(1<<18)-1];

  // DUT1: zero wait states, combinational SRAM model
  sram_mem_ctrl_if bus1 ();
  logic [17:0] addr1;
  logic [15:0] dq_out1, dq_in1;
  logic        oe1, we_n1;
  bit   [15:0] mem1 [0:(1<<18)-1];

`ifdef SRAM_MEM_CTRL_PERF_EN
  logic [31:0] sc0, sc1;
`endif

  sram_mem_ctrl #(.WaitCycles(1), .SramAw(18), .MemBase(1024)) dut0 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_bus      (bus0),
    .sram_addr_o  (addr0),
    .sram_dq_out_o(dq_out0),
    .sram_dq_oe_o (oe0),
    .sram_dq_in_i (dq_in0),
    .sram_we_n_o  (we_n0)
`ifdef SRAM_MEM_CTRL_PERF_EN
    ,
    .stall_count_o(sc0)
`endif
  );

  sram_mem_ctrl #(.WaitCycles(0), .SramAw(18), .MemBase(1024)) dut1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_bus      (bus1),
    .sram_addr_o  (addr1),
    .sram_dq_out_o(dq_out1),
    .sram_dq_oe_o (oe1),
    .sram_dq_in_i (dq_in1),
    .sram_we_n_o  (we_n1)
`ifdef SRAM_MEM_CTRL_PERF_EN
    ,
    .stall_count_o(sc1)
`endif
  );

  always @(posedge clk) begin
    if (!we_n0) mem0[addr0] <= dq_out0;
    dq_in0 <= mem0[addr0];
    if (!we_n1) mem1[addr1] <= dq_out1;
  end
  assign dq_in1 = mem1[addr1];

  // Reference model: half-word contents of the SRAM behind DUT0
  bit [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input int unsigned h);
    return ref_mem.exists(int'(h)) ? ref_mem[int'(h)] : 16'h0;
  endfunction

  // Low half-word index of the word at byte address a, wrapping over 2^18 half-words
  function automatic int unsigned ref_hw(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return (w % 131072) * 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full access on DUT0, checked against timing and the reference model
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int          cyc;
    int          we_cnt;
    logic [17:0] a_lo, a_hi;
    logic [15:0] d_lo, d_hi;
    int unsigned base;
    base = ref_hw(a);
    a_lo = 'x; a_hi = 'x; d_lo = 'x; d_hi = 'x;
    bus0.rd_en = rd; bus0.wr_en = wr; bus0.address = a; bus0.wr_data = d;
    #1;
    check("ready_cycle0", bus0.ready, 1'b0);
    cyc = 0;
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus0.ready) break;
      if (!we_n0) we_cnt++;
      if (cyc == 1) begin a_lo = addr0; d_lo = dq_out0; end
      if (cyc == 3) begin a_hi = addr0; d_hi = dq_out0; end
    end
    check("latency", cyc, 5);
    check("addr_lo", a_lo, base);
    check("addr_hi", a_hi, base + 1);
    check("we_cycles", we_cnt, wr ? 4 : 0);
    if (wr) begin
      ref_mem[int'(base)]     = d[15:0];
      ref_mem[int'(base + 1)] = d[31:16];
      check("wdata_lo", d_lo, d[15:0]);
      check("wdata_hi", d_hi, d[31:16]);
      check("sram_lo", mem0[base], ref_rd(base));
      check("sram_hi", mem0[base + 1], ref_rd(base + 1));
    end else begin
      check("rd_data", bus0.rd_data, {ref_rd(base + 1), ref_rd(base)});
    end
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned base;
    logic [31:0] a, d;
    int unsigned op;
`ifdef SRAM_MEM_CTRL_PERF_EN
    logic [31:0] sc_start;
`endif
    bus0.rd_en = 0; bus0.wr_en = 0; bus0.address = 0; bus0.wr_data = 0;
    bus1.rd_en = 0; bus1.wr_en = 0; bus1.address = 0; bus1.wr_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus0.ready, 1'b1);
    check("rst_we_n", we_n0, 1'b1);
    check("rst_oe", oe0, 1'b0);
    check("rst_addr", addr0, 0);
    check("rst_dq_out", dq_out0, 0);
    check("rst_rd_data", bus0.rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: write, read back, write at another word
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    check("t1_mem0", mem0[0], 16'hBEEF);
    check("t1_mem1", mem0[1], 16'hDEAD);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    check("t2_rd", bus0.rd_data, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1032, 32'h12345678);

    // Idle bus
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_ready", bus0.ready, 1'b1);
      check("idle_we_n", we_n0, 1'b1);
      check("idle_oe", oe0, 1'b0);
    end

    // Randomized accesses, including both requests high and wrapping addresses
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(1, 3);
      a  = 32'd1024 + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a + 32'h0008_0000;
      d  = $urandom;
      access(op[0], op[1], a, d);
    end

    // Reset in the middle of the high half of a write
    access(1'b0, 1'b1, 32'd1040, 32'hAAAA5555);
    base = ref_hw(32'd1040);
    bus0.wr_en = 1'b1; bus0.address = 32'd1040; bus0.wr_data = 32'h11112222;
    repeat (3) begin @(posedge clk); #1; end
    check("t5_in_hi_we_n", we_n0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_we_n", we_n0, 1'b1);
    check("t5_oe", oe0, 1'b0);
    bus0.wr_en = 1'b0;
    #1;
    check("t5_ready", bus0.ready, 1'b1);
    check("t5_rd_data", bus0.rd_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_mem[int'(base)] = 16'h2222;
    check("t5_sram_lo", mem0[base], ref_rd(base));
    check("t5_sram_hi", mem0[base + 1], 16'hAAAA);
    access(1'b1, 1'b0, 32'd1040, 32'h0);

    // Zero wait states: back-to-back read then write
    @(posedge clk); #1;
    bus1.rd_en = 1'b1; bus1.address = 32'd1024;
    #1;
`ifdef SRAM_MEM_CTRL_PERF_EN
    sc_start = sc1;
`endif
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      check("t6_ready", bus1.ready, (c == 3 || c == 7) ? 1'b1 : 1'b0);
      if (c == 3) begin
        bus1.rd_en = 1'b0; bus1.wr_en = 1'b1;
        bus1.address = 32'd1032; bus1.wr_data = 32'hCAFEF00D;
      end
    end
    check("t6_mem_lo", mem1[4], 16'hF00D);
    check("t6_mem_hi", mem1[5], 16'hCAFE);
`ifdef SRAM_MEM_CTRL_PERF_EN
    check("t6_stall", sc1 - sc_start, 32'd6);
`endif
    bus1.wr_en = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
